// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: reset/lock sequencer for the PLL on the 50 MHz refclk.
// It pulses pll_rst, waits for a synchronized and stable lock, and then
// releases sys_rst. Lock timeouts trigger a retry, and too many retries
// lead to FAIL. A lock loss while running re-sequences the PLL.
// Optional feature: define PLL_SEQ_LOSS_COUNT_EN to keep the saturating
// lock-loss counter. Without it, lock_lost_count is tied to zero.
module pll_lock_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       restart,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       lock_fail,
  output logic [7:0] retry_count,
  output logic [7:0] lock_lost_count
);

  localparam int MAX_AB  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CYC = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  // The counter is cleared on every state entry. The "last" values are
  // therefore the count observed on the edge that leaves the state.
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  // The edge that enters STABLE already counts as the first locked cycle.
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'((LOCK_STABLE_CYCLES >= 2) ? LOCK_STABLE_CYCLES - 2 : 0);
  localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       sync_reg;
  logic             locked_s;
  logic [7:0]       retry_reg;
  logic [7:0]       retry_next;
  logic             pll_rst_reg;
  logic             sys_rst_reg;
  logic             ready_reg;
  logic             lock_fail_reg;

  assign locked_s    = sync_reg[1];
  assign retry_next  = retry_reg + 8'd1;
  assign pll_rst     = pll_rst_reg;
  assign sys_rst     = sys_rst_reg;
  assign ready       = ready_reg;
  assign lock_fail   = lock_fail_reg;
  assign retry_count = retry_reg;

  // Two-flop synchronizer for the asynchronous PLL locked pin
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], pll_locked};
    end
  end

  // Sequencing FSM with registered outputs.
  // A restart re-enters PLL_RST exactly like a reset does, but it leaves the
  // synchronizer and the lock-loss counter untouched.
  always_ff @(posedge refclk) begin
    if (rst || restart) begin
      state_reg     <= S_PLL_RST;
      cnt_reg       <= '0;
      retry_reg     <= '0;
      pll_rst_reg   <= 1'b1;
      sys_rst_reg   <= 1'b1;
      ready_reg     <= 1'b0;
      lock_fail_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_PLL_RST: begin
          if (cnt_reg == PULSE_LAST) begin
            state_reg   <= S_WAIT_LOCK;
            cnt_reg     <= '0;
            pll_rst_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            cnt_reg <= '0;
            if (LOCK_STABLE_CYCLES == 1) begin
              state_reg   <= S_RUN;
              sys_rst_reg <= 1'b0;
              ready_reg   <= 1'b1;
              retry_reg   <= '0;
            end else begin
              state_reg <= S_STABLE;
            end
          end else if (cnt_reg == TIMEOUT_LAST) begin
            cnt_reg     <= '0;
            retry_reg   <= retry_next;
            pll_rst_reg <= 1'b1;
            if (retry_next == RETRY_LIMIT) begin
              state_reg     <= S_FAIL;
              lock_fail_reg <= 1'b1;
            end else begin
              state_reg <= S_PLL_RST;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        S_STABLE: begin
          if (!locked_s) begin
            // A dropout only resets the lock wait. It is not counted as a retry.
            state_reg <= S_WAIT_LOCK;
            cnt_reg   <= '0;
          end else if (cnt_reg == STABLE_LAST) begin
            state_reg   <= S_RUN;
            cnt_reg     <= '0;
            sys_rst_reg <= 1'b0;
            ready_reg   <= 1'b1;
            retry_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            state_reg   <= S_PLL_RST;
            cnt_reg     <= '0;
            pll_rst_reg <= 1'b1;
            sys_rst_reg <= 1'b1;
            ready_reg   <= 1'b0;
          end
        end
        S_FAIL: begin
          cnt_reg <= '0;
        end
        default: begin
          state_reg     <= S_PLL_RST;
          cnt_reg       <= '0;
          pll_rst_reg   <= 1'b1;
          sys_rst_reg   <= 1'b1;
          ready_reg     <= 1'b0;
          lock_fail_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_SEQ_LOSS_COUNT_EN
  logic [7:0] lost_reg;

  // Saturating count of lock losses seen in RUN; a restart keeps the history
  always_ff @(posedge refclk) begin
    if (rst) begin
      lost_reg <= '0;
    end else if (!restart && state_reg == S_RUN && !locked_s && lost_reg != 8'hFF) begin
      lost_reg <= lost_reg + 8'd1;
    end
  end

  assign lock_lost_count = lost_reg;
`else
  assign lock_lost_count = 8'd0;
`endif

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Reset/lock sequencer on the 50 MHz reference-clock domain, directly upstream of the Cyclone V fractional PLL wrapper.
- Drives the PLL `rst` input and consumes its `locked` output.
- Releases a system reset for the downstream 350 MHz adder datapath only after lock is stable.
- Retries on lock timeout, declares failure after a bounded number of retries, and re-sequences on loss of lock.

Parameters:
- RST_PULSE_CYCLES, 16: refclk cycles pll_rst is held high per PLL reset attempt (>=1).
- LOCK_TIMEOUT_CYCLES, 50000: refclk cycles to wait for lock before a retry (1 ms at 50 MHz).
- LOCK_STABLE_CYCLES, 256: consecutive synchronized-lock cycles required before sys_rst release (>=1).
- MAX_RETRIES, 3: lock timeouts tolerated before entering FAIL (1..255).
- CNT_W, localparam: $clog2 of the largest cycle parameter, plus 1.

Ports:
- refclk  in  1  50 MHz reference clock; all logic is on this edge.
- rst  in  1  synchronous, active-high reset.
- restart  in  1  single-cycle software request to re-run the full sequence.
- pll_locked  in  1  PLL `locked`; asynchronous to refclk.
- pll_rst  out  1  to PLL `rst`; registered.
- sys_rst  out  1  reset for downstream logic; registered, active-high.
- ready  out  1  high only in RUN.
- lock_fail  out  1  high only in FAIL.
- retry_count  out  8  timeouts in the current sequence.
- lock_lost_count  out  8  saturating count of RUN-state lock losses.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - state=PLL_RST, pll_rst=1, sys_rst=1, ready=0, lock_fail=0.
  - retry_count=0, lock_lost_count=0, counters=0, sync flops=0.
- pll_locked passes through a 2-flop synchronizer; locked_s lags the pin by 2 edges.
- PLL_RST:
  - pll_rst=1.
  - Counts RST_PULSE_CYCLES edges, then -> WAIT_LOCK.
  - pll_rst is high for exactly RST_PULSE_CYCLES cycles after rst release.
- WAIT_LOCK:
  - pll_rst=0; timeout counter increments each cycle.
  - locked_s=1 -> STABLE.
  - Counter reaches LOCK_TIMEOUT_CYCLES with locked_s=0 -> retry_count+1; if the new value == MAX_RETRIES -> FAIL, else -> PLL_RST.
- STABLE:
  - Stable counter counts cycles with locked_s=1.
  - locked_s=0 -> WAIT_LOCK with the timeout counter cleared; no retry increment.
  - After LOCK_STABLE_CYCLES consecutive high cycles (entry cycle counts as 1) -> RUN.
- RUN:
  - sys_rst=0, ready=1, retry_count cleared on entry.
  - locked_s=0 -> lock_lost_count+1 (saturating at 255), then -> PLL_RST. sys_rst reasserts on the same edge that leaves RUN.
- FAIL:
  - pll_rst=1, sys_rst=1, lock_fail=1.
  - Exits only on restart or rst.
- Output timing:
  - sys_rst=1 in every state except RUN.
  - Outputs are registered and change on the same edge as the state.
- restart=1 in any state -> PLL_RST:
  - All counters cleared, retry_count=0, lock_fail=0.
  - lock_lost_count is preserved.
  - restart in PLL_RST restarts the pulse.
- rst has priority over restart.
- locked glitches shorter than 1 refclk cycle need not be detected.
- Counters never wrap: the timeout and stable counters clear on every state change.

Optional Feature:
- Macro: PLL_SEQ_LOSS_COUNT_EN.
- Defined: lock_lost_count behaves as specified above.
- Not defined: lock_lost_count is constant 0, its counter register is removed, and RUN->PLL_RST on lock loss is otherwise unchanged.

Test Plan:
All scenarios use RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2, with PLL_SEQ_LOSS_COUNT_EN defined.
1. Nominal lock:
   - Release rst at edge 0; pll_locked=1 from edge 10.
   - pll_rst falls after edge 4; locked_s high at edge 12; sys_rst=0 and ready=1 after edge 19; retry_count=0.
2. Timeout to FAIL:
   - pll_locked held 0.
   - Two timeouts occur; retry_count 1 then 2.
   - lock_fail=1 after edge 4+20+4+20=48; pll_rst=1 and sys_rst=1 held indefinitely.
3. Restart out of FAIL:
   - From scenario 2, pulse restart for 1 cycle, then pll_locked=1.
   - lock_fail=0 the next cycle, retry_count=0, new 4-cycle pll_rst pulse, then RUN.
4. Stability glitch:
   - In STABLE, drop pll_locked for 3 cycles at stable count 5, then raise it.
   - State returns to WAIT_LOCK; sys_rst stays 1; RUN is reached only after 8 fresh consecutive locked_s cycles; retry_count unchanged.
5. Loss in RUN:
   - In RUN, drop pll_locked.
   - 2 edges later sys_rst=1, ready=0, pll_rst=1, lock_lost_count=1.
   - Relock returns to RUN.
   - 300 repeated losses saturate the count at 255.
6. Mid-operation reset:
   - Assert rst during STABLE with restart=1 on the same cycle.
   - All outputs return to reset values, including lock_lost_count=0; the sequence restarts from PLL_RST.
